// File: rtl/auto_manual_seq_ctrl_if.sv
// Control and display bundle between the demo front panel and the sequencing controller.
// The master side drives switches/buttons; the slave side returns the display value, mode and tick.
interface auto_manual_seq_ctrl_if;
    logic       auto;
    logic       load;
    logic       pause;
    logic       step;
    logic       up_down;
    logic [3:0] s_sw;
    logic [3:0] s_op;
    logic [1:0] mode;
    logic       tick;

    modport master (
        output auto, load, pause, step, up_down, s_sw,
        input  s_op, mode, tick
    );

    modport slave (
        input  auto, load, pause, step, up_down, s_sw,
        output s_op, mode, tick
    );
endinterface

// File: rtl/auto_manual_seq_ctrl.sv
// Auto/manual sequencing controller for the 4-bit display value: switch pass-through in manual,
// prescaled up/down counter with run/pause/step/load in auto.
module auto_manual_seq_ctrl #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    auto_manual_seq_ctrl_if.slave   bus
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MANUAL     = 2'b00,
        AUTO_RUN   = 2'b01,
        AUTO_PAUSE = 2'b10
    } state_t;

    state_t             state, state_next;
    logic [3:0]         counter, counter_next;
    logic [PRE_W-1:0]   presc, presc_next;
    logic [3:0]         s_op_q, s_op_next;

    logic [4:0]         sync_q [SYNC_STAGES];
    logic [4:0]         raw;
    logic [4:0]         synced;
    logic [3:0]         prev_q;
    logic [3:0]         rise;

    logic               auto_s, up_down_s;
    logic               auto_rise, load_rise, pause_rise, step_rise;
    logic               tick_int;
    logic [3:0]         count_step;

    // Bit order: {up_down, step, pause, load, auto}
    assign raw        = {bus.up_down, bus.step, bus.pause, bus.load, bus.auto};
    assign synced     = sync_q[SYNC_STAGES-1];
    assign rise       = synced[3:0] & ~prev_q;
    assign auto_s     = synced[0];
    assign up_down_s  = synced[4];
    assign auto_rise  = rise[0];
    assign load_rise  = rise[1];
    assign pause_rise = rise[2];
    assign step_rise  = rise[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= synced[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MANUAL;
            counter <= '0;
            presc   <= '0;
            s_op_q  <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            presc   <= presc_next;
            s_op_q  <= s_op_next;
        end
    end

    assign tick_int   = (state == AUTO_RUN) && (presc == PRE_LAST);
    assign count_step = up_down_s ? 4'(counter + 4'd1) : 4'(counter - 4'd1);

    // Priority inside the auto states: auto low, then load, then tick/step; pause toggles independently.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        presc_next   = presc;
        s_op_next    = (state == MANUAL) ? bus.s_sw : counter;

        case (state)
            MANUAL: begin
                if (auto_rise) begin
                    state_next   = AUTO_RUN;
                    counter_next = bus.s_sw;
                    presc_next   = '0;
                end
            end
            AUTO_RUN: begin
                if (!auto_s) begin
                    state_next = MANUAL;
                end else begin
                    presc_next = tick_int ? '0 : PRE_W'(presc + PRE_W'(1));
                    if (load_rise) begin
                        counter_next = bus.s_sw;
                        presc_next   = '0;
                    end else if (tick_int) begin
                        counter_next = count_step;
                    end
                    if (pause_rise) begin
                        state_next = AUTO_PAUSE;
                    end
                end
            end
            AUTO_PAUSE: begin
                if (!auto_s) begin
                    state_next = MANUAL;
                end else begin
                    if (load_rise) begin
                        counter_next = bus.s_sw;
                        presc_next   = '0;
                    end else if (step_rise) begin
                        counter_next = count_step;
                    end
                    if (pause_rise) begin
                        state_next = AUTO_RUN;
                    end
                end
            end
            default: begin
                state_next = MANUAL;
            end
        endcase
    end

    assign bus.s_op = s_op_q;
    assign bus.mode = state;
    assign bus.tick = tick_int;

endmodule

// File: tb/tb_auto_manual_seq_ctrl.sv
// Directed self-checking bench for auto_manual_seq_ctrl with TICK_DIV=4 and two-stage synchronizers.
// Stimulus changes and sampling both happen 1 time unit after the rising clock edge.
module tb_auto_manual_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic tick_flag;

    always #5 clk = ~clk;

    auto_manual_seq_ctrl_if bus();

    auto_manual_seq_ctrl #(
        .TICK_DIV    (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.tick === 1'b1) tick_flag = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic a, input logic ud, input logic [3:0] sw);
        bus.auto    = a;
        bus.up_down = ud;
        bus.s_sw    = sw;
    endtask

    // 0 = load, 1 = pause, 2 = step; held high for exactly one clock
    task automatic pressButton(input int which);
        case (which)
            0: bus.load  = 1'b1;
            1: bus.pause = 1'b1;
            default: bus.step = 1'b1;
        endcase
        cycles(1);
        bus.load  = 1'b0;
        bus.pause = 1'b0;
        bus.step  = 1'b0;
    endtask

    task automatic waitTick();
        int k;
        k = 0;
        do begin
            cycles(1);
            k++;
        end while (bus.tick !== 1'b1 && k < 8);
        checkOutput("tick_seen", {31'd0, bus.tick}, 32'd1);
    endtask

    task automatic nextCount(input string tag, input logic [3:0] expected);
        waitTick();
        cycles(2);
        checkOutput(tag, {28'd0, bus.s_op}, {28'd0, expected});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        bus.load  = 1'b0;
        bus.pause = 1'b0;
        bus.step  = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'hA);
        tick_flag = 1'b0;

        #2;
        checkOutput("reset_s_op", {28'd0, bus.s_op}, 32'd0);
        checkOutput("reset_mode", {30'd0, bus.mode}, 32'd0);
        checkOutput("reset_tick", {31'd0, bus.tick}, 32'd0);
        cycles(2);
        checkOutput("reset_held_s_op", {28'd0, bus.s_op}, 32'd0);

        // Manual pass-through
        rst_n = 1'b1;
        cycles(2);
        checkOutput("manual_s_op", {28'd0, bus.s_op}, 32'hA);
        checkOutput("manual_mode", {30'd0, bus.mode}, 32'd0);
        cycles(6);
        checkOutput("manual_no_tick", {31'd0, tick_flag}, 32'd0);

        // Bumpless entry into AUTO_RUN and tick spacing
        applyStimulus(1'b1, 1'b1, 4'd3);
        cycles(2);
        checkOutput("auto_latency_mode", {30'd0, bus.mode}, 32'd0);
        cycles(1);
        checkOutput("auto_mode", {30'd0, bus.mode}, 32'd1);
        checkOutput("auto_s_op", {28'd0, bus.s_op}, 32'd3);
        cycles(3);
        checkOutput("first_tick", {31'd0, bus.tick}, 32'd1);
        cycles(1);
        checkOutput("tick_one_wide", {31'd0, bus.tick}, 32'd0);
        checkOutput("s_op_before_inc", {28'd0, bus.s_op}, 32'd3);
        cycles(1);
        checkOutput("count_4", {28'd0, bus.s_op}, 32'd4);
        nextCount("count_5", 4'd5);
        nextCount("count_6", 4'd6);

        // Up wrap, then down wrap
        applyStimulus(1'b1, 1'b1, 4'd14);
        pressButton(0);
        cycles(3);
        checkOutput("load_14", {28'd0, bus.s_op}, 32'd14);
        nextCount("up_15", 4'd15);
        nextCount("up_wrap_0", 4'd0);
        nextCount("up_1", 4'd1);
        applyStimulus(1'b1, 1'b0, 4'd14);
        nextCount("down_0", 4'd0);
        nextCount("down_wrap_15", 4'd15);

        // Pause at 7, hold, single steps, resume
        applyStimulus(1'b1, 1'b1, 4'd6);
        pressButton(0);
        cycles(3);
        checkOutput("load_6", {28'd0, bus.s_op}, 32'd6);
        waitTick();
        pressButton(1);
        cycles(2);
        checkOutput("pause_mode", {30'd0, bus.mode}, 32'd2);
        checkOutput("pause_s_op", {28'd0, bus.s_op}, 32'd7);
        tick_flag = 1'b0;
        cycles(20);
        checkOutput("pause_hold_s_op", {28'd0, bus.s_op}, 32'd7);
        checkOutput("pause_no_tick", {31'd0, tick_flag}, 32'd0);
        pressButton(2);
        cycles(3);
        checkOutput("step_8", {28'd0, bus.s_op}, 32'd8);
        pressButton(2);
        cycles(3);
        checkOutput("step_9", {28'd0, bus.s_op}, 32'd9);
        pressButton(1);
        cycles(2);
        checkOutput("resume_mode", {30'd0, bus.mode}, 32'd1);
        cycles(1);
        checkOutput("resume_held_presc_tick", {31'd0, bus.tick}, 32'd1);
        cycles(2);
        checkOutput("resume_10", {28'd0, bus.s_op}, 32'd10);

        // Load landing on the same edge as a tick
        waitTick();
        cycles(2);
        applyStimulus(1'b1, 1'b1, 4'hC);
        pressButton(0);
        cycles(1);
        checkOutput("load_tick_coincide", {31'd0, bus.tick}, 32'd1);
        cycles(2);
        checkOutput("load_beats_tick", {28'd0, bus.s_op}, 32'hC);
        cycles(1);
        checkOutput("post_load_no_tick", {31'd0, bus.tick}, 32'd0);
        cycles(1);
        checkOutput("post_load_tick_4", {31'd0, bus.tick}, 32'd1);
        cycles(2);
        checkOutput("post_load_inc", {28'd0, bus.s_op}, 32'hD);

        // Pause coinciding with tick keeps the increment; then leave auto
        pressButton(1);
        cycles(2);
        checkOutput("pause_tick_mode", {30'd0, bus.mode}, 32'd2);
        cycles(1);
        checkOutput("pause_tick_inc", {28'd0, bus.s_op}, 32'd14);
        applyStimulus(1'b0, 1'b1, 4'd5);
        cycles(2);
        checkOutput("auto_off_latency", {30'd0, bus.mode}, 32'd2);
        cycles(1);
        checkOutput("auto_off_mode", {30'd0, bus.mode}, 32'd0);
        cycles(1);
        checkOutput("auto_off_s_op", {28'd0, bus.s_op}, 32'd5);

        // Asynchronous reset mid-count
        applyStimulus(1'b1, 1'b1, 4'd2);
        cycles(3);
        checkOutput("rerun_mode", {30'd0, bus.mode}, 32'd1);
        checkOutput("rerun_s_op", {28'd0, bus.s_op}, 32'd2);
        cycles(5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_s_op", {28'd0, bus.s_op}, 32'd0);
        checkOutput("async_rst_mode", {30'd0, bus.mode}, 32'd0);
        checkOutput("async_rst_tick", {31'd0, bus.tick}, 32'd0);
        #2;
        rst_n = 1'b1;
        cycles(2);
        checkOutput("post_rst_mode", {30'd0, bus.mode}, 32'd0);
        cycles(1);
        checkOutput("post_rst_auto_mode", {30'd0, bus.mode}, 32'd1);
        checkOutput("post_rst_auto_s_op", {28'd0, bus.s_op}, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
